cpu_clk_seq: RTL and testbench

//  Parametrised CPU clock/reset sequencer fed from the 12 MHz board clock hwclk.

---
 rtl/cpu_clk_seq.sv | 143 ++++++++++++++
 tb/tb_cpu_clk_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_seq.sv
// CPU clock/reset sequencer: divides hwclk into a square-wave CPU clock with tick enable,
// supports halt/run/fast/single-step modes and produces periodic CPU reset pulses.
module cpu_clk_seq #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_LEN    = 1,
    parameter int unsigned RST_PERIOD = 16,
    parameter int unsigned DEB_W      = 16
) (
    input  logic             hwclk,
    input  logic             res,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div,
    input  logic             step_btn,
    input  logic             rst_req,
    output logic             cpu_clk,
    output logic             cpu_tick,
    output logic             cpu_res,
    output logic [7:0]       tick_cnt
);

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    logic             sync1, sync2, deb_level;
    logic [DEB_W-1:0] deb_cnt;
    logic             press_c;

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] div_eff_c;
    logic             terminal_c;
    logic             step_busy, busy_nx;
    logic             clk_nx, tick_nx;

    logic [7:0]       seq_nx_c;
    logic             res_nx_c;

    // Button synchroniser and debouncer; a press is the debounced level rising.
    assign press_c = sync2 & ~deb_level & (&deb_cnt);

    always_ff @(posedge hwclk or posedge res) begin
        if (res) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (&deb_cnt) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Effective half-period; >= lets a shrinking div end the current half-period at once.
    assign div_eff_c  = (mode == MODE_FAST || div == '0) ? CNT_W'(1) : div;
    assign terminal_c = (cnt >= div_eff_c - CNT_W'(1));

    always_comb begin
        cnt_nx  = cnt;
        clk_nx  = cpu_clk;
        tick_nx = 1'b0;
        busy_nx = 1'b0;
        case (mode)
            MODE_RUN, MODE_FAST: begin
                if (terminal_c) begin
                    cnt_nx  = '0;
                    clk_nx  = ~cpu_clk;
                    tick_nx = ~cpu_clk;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            MODE_STEP: begin
                busy_nx = step_busy;
                if (cpu_clk) begin
                    if (terminal_c) begin
                        cnt_nx  = '0;
                        clk_nx  = 1'b0;
                        busy_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_nx = '0;
                    if (press_c && !step_busy) begin
                        clk_nx  = 1'b1;
                        tick_nx = 1'b1;
                        busy_nx = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hwclk or posedge res) begin
        if (res) begin
            cnt       <= '0;
            cpu_clk   <= 1'b0;
            cpu_tick  <= 1'b0;
            step_busy <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            cpu_clk   <= clk_nx;
            cpu_tick  <= tick_nx;
            step_busy <= busy_nx;
        end
    end

    // Reset-sequence position: wraps at RST_PERIOD, saturates at 255 when non-periodic.
    always_comb begin
        if (RST_PERIOD != 0 && tick_cnt == 8'(RST_PERIOD - 1)) begin
            seq_nx_c = 8'd0;
        end else if (tick_cnt == 8'hFF) begin
            seq_nx_c = 8'hFF;
        end else begin
            seq_nx_c = tick_cnt + 8'd1;
        end
        res_nx_c = (32'(seq_nx_c) < 32'(RST_LEN));
    end

    always_ff @(posedge hwclk or posedge res) begin
        if (res) begin
            tick_cnt <= 8'd0;
            cpu_res  <= 1'b1;
        end else if (rst_req) begin
            tick_cnt <= 8'd0;
            cpu_res  <= 1'b1;
        end else if (cpu_tick) begin
            tick_cnt <= seq_nx_c;
            cpu_res  <= res_nx_c;
        end
    end

endmodule

// File: tb/tb_cpu_clk_seq.sv
// Randomised self-checking bench for cpu_clk_seq against a closed-form timing model.
module tb_cpu_clk_seq;

    logic        hwclk;
    logic        res;
    logic [1:0]  mode;
    logic [31:0] div;
    logic        step_btn;
    logic        rst_req;
    logic        cpu_clk, cpu_tick, cpu_res;
    logic [7:0]  tick_cnt;
    logic        clk_b, tick_b, res_b;
    logic [7:0]  cnt_b;

    int vec  = 0;
    int miss = 0;

    cpu_clk_seq #(.CNT_W(32), .RST_LEN(1), .RST_PERIOD(16), .DEB_W(2)) u_dut (
        .hwclk(hwclk), .res(res), .mode(mode), .div(div), .step_btn(step_btn),
        .rst_req(rst_req), .cpu_clk(cpu_clk), .cpu_tick(cpu_tick),
        .cpu_res(cpu_res), .tick_cnt(tick_cnt)
    );

    cpu_clk_seq #(.CNT_W(32), .RST_LEN(1), .RST_PERIOD(0), .DEB_W(2)) u_dut0 (
        .hwclk(hwclk), .res(res), .mode(mode), .div(div), .step_btn(step_btn),
        .rst_req(rst_req), .cpu_clk(clk_b), .cpu_tick(tick_b),
        .cpu_res(res_b), .tick_cnt(cnt_b)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic step_cyc;
        @(posedge hwclk);
        #1;
    endtask

    // Pulse res away from clock edges; the next posedge is edge 1 after release.
    task automatic pulse_res;
        res = 1'b1;
        #2;
        @(posedge hwclk);
        #2;
        res = 1'b0;
    endtask

    task automatic test_reset;
        res = 1'b1; mode = 2'b01; div = 32'd3; step_btn = 1'b0; rst_req = 1'b0;
        #3;
        vec++;
        if ({cpu_clk, cpu_tick, cpu_res, tick_cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            miss++;
            $display("FAIL reset_a got clk/tick/res/cnt=%b/%b/%b/%0d exp 0/0/1/0", cpu_clk, cpu_tick, cpu_res, tick_cnt);
        end
        vec++;
        if ({clk_b, tick_b, res_b, cnt_b} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            miss++;
            $display("FAIL reset_b got clk/tick/res/cnt=%b/%b/%b/%0d exp 0/0/1/0", clk_b, tick_b, res_b, cnt_b);
        end
        for (int i = 0; i < 4; i++) step_cyc();
        vec++;
        if ({cpu_clk, cpu_tick, cpu_res} !== 3'b001) begin
            miss++;
            $display("FAIL reset_hold got clk/tick/res=%b/%b/%b exp 0/0/1", cpu_clk, cpu_tick, cpu_res);
        end
        #1;
        res = 1'b0;
    endtask

    // Free-running model: after k edges, clk = (k/D)%2, tick when k%(2D)==D; the reset
    // position is ticks completed since the last restart, modulo the period.
    task automatic test_run_model(input int dv, input bit fast, input int n, input int req_pct);
        int  d, ts, km1;
        bit  req;
        logic [10:0] got, exp;
        mode = fast ? 2'b11 : 2'b01;
        div  = 32'(dv);
        pulse_res();
        d  = fast ? 1 : ((dv == 0) ? 1 : dv);
        ts = 0;
        for (int k = 1; k <= n; k++) begin
            req = ($urandom_range(99) < 32'(req_pct));
            rst_req = req;
            @(posedge hwclk);
            #1;
            rst_req = 1'b0;
            km1 = k - 1;
            if (req) ts = 0;
            else if (km1 % (2 * d) == d) ts++;
            exp = {1'((k / d) % 2), 1'(k % (2 * d) == d), 1'((ts % 16) < 1), 8'(ts % 16)};
            got = {cpu_clk, cpu_tick, cpu_res, tick_cnt};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL run d=%0d fast=%0d k=%0d got clk/tick/res/cnt=%b/%b/%b/%0d exp %b/%b/%b/%0d",
                         d, fast, k, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_div_change;
        logic [1:0] exp_seq [4];
        mode = 2'b01; div = 32'd5;
        pulse_res();
        for (int i = 0; i < 3; i++) step_cyc();
        vec++;
        if (cpu_clk !== 1'b0) begin
            miss++;
            $display("FAIL div5_cnt3 clk got %b exp 0", cpu_clk);
        end
        div = 32'd2;
        step_cyc();
        vec++;
        if ({cpu_clk, cpu_tick} !== 2'b11) begin
            miss++;
            $display("FAIL div_shrink clk/tick got %b/%b exp 1/1", cpu_clk, cpu_tick);
        end
        div = 32'd0;
        exp_seq[0] = 2'b00; exp_seq[1] = 2'b11; exp_seq[2] = 2'b00; exp_seq[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step_cyc();
            vec++;
            if ({cpu_clk, cpu_tick} !== exp_seq[i]) begin
                miss++;
                $display("FAIL div0 cyc=%0d clk/tick got %b/%b exp %b/%b", i, cpu_clk, cpu_tick, exp_seq[i][1], exp_seq[i][0]);
            end
        end
    endtask

    task automatic test_step;
        int ticks, high, bad;
        mode = 2'b10; div = 32'd3; step_btn = 1'b0;
        pulse_res();
        ticks = 0; high = 0; bad = 0;
        step_btn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) step_btn = 1'b0;
            step_cyc();
            if (cpu_tick) begin ticks++; if (!cpu_clk) bad++; end
            if (cpu_clk) high++;
        end
        vec++;
        if (ticks !== 1 || high !== 3 || bad !== 0) begin
            miss++;
            $display("FAIL step_press ticks/high/misaligned got %0d/%0d/%0d exp 1/3/0", ticks, high, bad);
        end
        ticks = 0;
        step_btn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) step_btn = 1'b0;
            step_cyc();
            if (cpu_tick) ticks++;
        end
        vec++;
        if (ticks !== 0) begin
            miss++;
            $display("FAIL step_glitch ticks got %0d exp 0", ticks);
        end
        div = 32'd20;
        ticks = 0; high = 0;
        step_btn = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 8)  step_btn = 1'b0;
            if (c == 16) step_btn = 1'b1;
            if (c == 30) step_btn = 1'b0;
            step_cyc();
            if (cpu_tick) ticks++;
            if (cpu_clk) high++;
        end
        vec++;
        if (ticks !== 1 || high !== 20) begin
            miss++;
            $display("FAIL step_busy_discard ticks/high got %0d/%0d exp 1/20", ticks, high);
        end
    endtask

    task automatic test_halt;
        mode = 2'b01; div = 32'd4;
        pulse_res();
        for (int i = 0; i < 6; i++) step_cyc();
        mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step_cyc();
            vec++;
            if ({cpu_clk, cpu_tick} !== 2'b10) begin
                miss++;
                $display("FAIL halt_freeze cyc=%0d clk/tick got %b/%b exp 1/0", i, cpu_clk, cpu_tick);
            end
        end
        vec++;
        if ({cpu_res, tick_cnt} !== {1'b0, 8'd1}) begin
            miss++;
            $display("FAIL halt_seq res/cnt got %b/%0d exp 0/1", cpu_res, tick_cnt);
        end
        rst_req = 1'b1;
        step_cyc();
        rst_req = 1'b0;
        vec++;
        if ({cpu_res, tick_cnt} !== {1'b1, 8'd0}) begin
            miss++;
            $display("FAIL halt_rst_req res/cnt got %b/%0d exp 1/0", cpu_res, tick_cnt);
        end
        mode = 2'b01;
        step_cyc();
        vec++;
        if (cpu_clk !== 1'b1) begin
            miss++;
            $display("FAIL resume_cnt3 clk got %b exp 1", cpu_clk);
        end
        for (int i = 0; i < 4; i++) begin
            step_cyc();
            vec++;
            if ({cpu_clk, cpu_tick} !== 2'b00) begin
                miss++;
                $display("FAIL resume_low cyc=%0d clk/tick got %b/%b exp 0/0", i, cpu_clk, cpu_tick);
            end
        end
        step_cyc();
        vec++;
        if ({cpu_clk, cpu_tick, cpu_res} !== 3'b111) begin
            miss++;
            $display("FAIL resume_tick clk/tick/res got %b/%b/%b exp 1/1/1", cpu_clk, cpu_tick, cpu_res);
        end
    endtask

    task automatic test_rst_req_tick;
        mode = 2'b01; div = 32'd3;
        pulse_res();
        for (int i = 0; i < 9; i++) step_cyc();
        vec++;
        if ({cpu_tick, cpu_res, tick_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            miss++;
            $display("FAIL second_tick tick/res/cnt got %b/%b/%0d exp 1/0/1", cpu_tick, cpu_res, tick_cnt);
        end
        rst_req = 1'b1;
        step_cyc();
        rst_req = 1'b0;
        vec++;
        if ({cpu_res, tick_cnt} !== {1'b1, 8'd0}) begin
            miss++;
            $display("FAIL req_in_tick res/cnt got %b/%0d exp 1/0", cpu_res, tick_cnt);
        end
        for (int i = 0; i < 6; i++) step_cyc();
        vec++;
        if ({cpu_res, tick_cnt} !== {1'b0, 8'd1}) begin
            miss++;
            $display("FAIL after_req_tick res/cnt got %b/%0d exp 0/1", cpu_res, tick_cnt);
        end
    endtask

    task automatic test_res_mid_high;
        mode = 2'b01; div = 32'd3;
        pulse_res();
        for (int i = 0; i < 4; i++) step_cyc();
        res = 1'b1;
        #2;
        vec++;
        if ({cpu_clk, cpu_tick, cpu_res, tick_cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            miss++;
            $display("FAIL res_mid_high clk/tick/res/cnt got %b/%b/%b/%0d exp 0/0/1/0", cpu_clk, cpu_tick, cpu_res, tick_cnt);
        end
        @(posedge hwclk);
        #2;
        res = 1'b0;
    endtask

    task automatic test_period0;
        mode = 2'b01; div = 32'd1;
        pulse_res();
        step_cyc();
        vec++;
        if ({tick_b, res_b, cnt_b} !== {1'b1, 1'b1, 8'd0}) begin
            miss++;
            $display("FAIL p0_first tick/res/cnt got %b/%b/%0d exp 1/1/0", tick_b, res_b, cnt_b);
        end
        step_cyc();
        vec++;
        if ({res_b, cnt_b} !== {1'b0, 8'd1}) begin
            miss++;
            $display("FAIL p0_second res/cnt got %b/%0d exp 0/1", res_b, cnt_b);
        end
        for (int i = 0; i < 598; i++) step_cyc();
        vec++;
        if ({res_b, cnt_b} !== {1'b0, 8'd255}) begin
            miss++;
            $display("FAIL p0_saturate res/cnt got %b/%0d exp 0/255", res_b, cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_run_model(3, 1'b0, 120, 0);
        test_div_change();
        test_step();
        test_halt();
        test_rst_req_tick();
        test_res_mid_high();
        test_period0();
        for (int i = 0; i < 8; i++) begin
            test_run_model($urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom_range(40, 200), 5);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
